// File: rtl/median_window_if.sv
// Pixel-stream handshake and window-status bundle between the pixel source and
// the median-filter window sequencer.
interface median_window_if #(
    parameter int CNT_W = 10
);
    logic             pix_valid;
    logic             pix_sof;
    logic             pix_ready;
    logic             shift_en;
    logic             win_valid;
    logic [CNT_W-1:0] out_col;
    logic [CNT_W-1:0] out_row;
    logic             brd_top;
    logic             brd_bot;
    logic             brd_lft;
    logic             brd_rgt;
    logic             frame_done;
    logic             err_sof;

    modport master (
        output pix_valid, pix_sof,
        input  pix_ready, shift_en, win_valid, out_col, out_row,
        input  brd_top, brd_bot, brd_lft, brd_rgt, frame_done, err_sof
    );

    modport slave (
        input  pix_valid, pix_sof,
        output pix_ready, shift_en, win_valid, out_col, out_row,
        output brd_top, brd_bot, brd_lft, brd_rgt, frame_done, err_sof
    );
endinterface

// File: rtl/median_window_ctrl.sv
// Raster sequencer for the median-filter line-buffer chain: drives the line-delay
// shift, reports each completed WINxWIN window and flushes the chain after the frame.
module median_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 3,
    parameter int CNT_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    median_window_if.slave bus
);
    localparam int HALF = (WIN - 1) / 2;
    localparam int LAG  = HALF * IMG_W + HALF;
    localparam int FL_W = $clog2(LAG + 2);

    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] BOT_LIM  = CNT_W'(IMG_H - 1 - HALF);
    localparam logic [CNT_W-1:0] RGT_LIM  = CNT_W'(IMG_W - 1 - HALF);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(LAG - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Raster successor of (col,row); packed as {row, col}, wrapping after the last pixel.
    function automatic logic [2*CNT_W-1:0] next_pos(input logic [CNT_W-1:0] col,
                                                    input logic [CNT_W-1:0] row);
        logic [CNT_W-1:0] ncol;
        logic [CNT_W-1:0] nrow;
        if (col == LAST_COL) begin
            ncol = ZERO_C;
            nrow = (row == LAST_ROW) ? ZERO_C : row + CNT_W'(1);
        end else begin
            ncol = col + CNT_W'(1);
            nrow = row;
        end
        return {nrow, ncol};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    state_t           entry_s;
    logic [CNT_W-1:0] in_col_r;
    logic [CNT_W-1:0] in_row_r;
    logic [CNT_W-1:0] win_col_r;
    logic [CNT_W-1:0] win_row_r;
    logic [FL_W-1:0]  flush_cnt_r;
    logic             win_valid_r;
    logic [CNT_W-1:0] out_col_r;
    logic [CNT_W-1:0] out_row_r;
    logic             brd_top_r;
    logic             brd_bot_r;
    logic             brd_lft_r;
    logic             brd_rgt_r;
    logic             frame_done_r;
    logic             err_sof_r;

    logic             ready_s;
    logic             accept_s;
    logic             restart_s;
    logic             in_shift_s;
    logic             past_lag_s;
    logic             last_pix_s;
    logic             produce_s;
    logic             shift_s;
    logic [CNT_W-1:0] acc_col_s;
    logic [CNT_W-1:0] acc_row_s;
    logic [CNT_W-1:0] base_col_s;
    logic [CNT_W-1:0] base_row_s;
    logic [2*CNT_W-1:0] in_next_s;
    logic [2*CNT_W-1:0] win_next_s;

    // Accept/shift decode; an SOF accept re-bases both the input and the window position at (0,0).
    always_comb begin
        ready_s    = (state_r == ST_IDLE) || (state_r == ST_FILL) || (state_r == ST_RUN);
        accept_s   = bus.pix_valid & ready_s;
        restart_s  = accept_s & bus.pix_sof;
        in_shift_s = accept_s & ((state_r != ST_IDLE) | bus.pix_sof);
        if (restart_s) begin
            acc_col_s  = ZERO_C;
            acc_row_s  = ZERO_C;
            base_col_s = ZERO_C;
            base_row_s = ZERO_C;
        end else begin
            acc_col_s  = in_col_r;
            acc_row_s  = in_row_r;
            base_col_s = win_col_r;
            base_row_s = win_row_r;
        end
        // Pixel index >= LAG is exactly position (HALF,HALF) or later in raster order.
        past_lag_s = (acc_row_s > HALF_C) || ((acc_row_s == HALF_C) && (acc_col_s >= HALF_C));
        last_pix_s = (acc_col_s == LAST_COL) && (acc_row_s == LAST_ROW);
        produce_s  = (in_shift_s & past_lag_s) | (state_r == ST_FLUSH);
        shift_s    = in_shift_s | (state_r == ST_FLUSH);
        in_next_s  = next_pos(acc_col_s, acc_row_s);
        win_next_s = next_pos(base_col_s, base_row_s);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (last_pix_s) begin
            entry_s = (LAG == 0) ? ST_DONE : ST_FLUSH;
        end else if (past_lag_s) begin
            entry_s = ST_RUN;
        end else begin
            entry_s = ST_FILL;
        end
        case (state_r)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (in_shift_s) begin
                    state_nxt_s = entry_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FL_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Flush length counter, only running while the chain drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {FL_W{1'b0}};
        end else if (state_r == ST_FLUSH) begin
            flush_cnt_r <= flush_cnt_r + FL_W'(1);
        end else begin
            flush_cnt_r <= {FL_W{1'b0}};
        end
    end

    // Input raster position of the next expected pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col_r <= ZERO_C;
            in_row_r <= ZERO_C;
        end else if (in_shift_s) begin
            {in_row_r, in_col_r} <= in_next_s;
        end else begin
            in_col_r <= in_col_r;
            in_row_r <= in_row_r;
        end
    end

    // Raster position of the next window centre; an aborted frame restarts it at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_col_r <= ZERO_C;
            win_row_r <= ZERO_C;
        end else if (produce_s) begin
            {win_row_r, win_col_r} <= win_next_s;
        end else if (restart_s) begin
            win_col_r <= ZERO_C;
            win_row_r <= ZERO_C;
        end else begin
            win_col_r <= win_col_r;
            win_row_r <= win_row_r;
        end
    end

    // Registered window report, one cycle behind the producing shift like the line delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_r <= 1'b0;
            out_col_r   <= ZERO_C;
            out_row_r   <= ZERO_C;
            brd_top_r   <= 1'b0;
            brd_bot_r   <= 1'b0;
            brd_lft_r   <= 1'b0;
            brd_rgt_r   <= 1'b0;
        end else begin
            win_valid_r <= produce_s;
            if (produce_s) begin
                out_col_r <= base_col_s;
                out_row_r <= base_row_s;
            end else begin
                out_col_r <= out_col_r;
                out_row_r <= out_row_r;
            end
            brd_top_r <= produce_s & (base_row_s < HALF_C);
            brd_bot_r <= produce_s & (base_row_s > BOT_LIM);
            brd_lft_r <= produce_s & (base_col_s < HALF_C);
            brd_rgt_r <= produce_s & (base_col_s > RGT_LIM);
        end
    end

    // Status pulses: end of frame, and SOF protocol violations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
            err_sof_r    <= 1'b0;
        end else begin
            frame_done_r <= (state_r == ST_DONE);
            err_sof_r    <= accept_s & ((state_r == ST_IDLE) ? ~bus.pix_sof : bus.pix_sof);
        end
    end

    assign bus.pix_ready  = ready_s;
    assign bus.shift_en   = shift_s;
    assign bus.win_valid  = win_valid_r;
    assign bus.out_col    = out_col_r;
    assign bus.out_row    = out_row_r;
    assign bus.brd_top    = brd_top_r;
    assign bus.brd_bot    = brd_bot_r;
    assign bus.brd_lft    = brd_lft_r;
    assign bus.brd_rgt    = brd_rgt_r;
    assign bus.frame_done = frame_done_r;
    assign bus.err_sof    = err_sof_r;
endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl on a 4x3 image with a 3x3 window,
// using a pixel-count based reference model plus pinned literal expectations.
module tb_median_window_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int HALF = 1;
    localparam int LAG  = 5;
    localparam int CW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_window_if #(.CNT_W(CW)) bus ();

    median_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(3), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int test_id = 0;

    int n_shift, n_win, n_fd, n_err, n_nrdy;
    int first_win_cyc, first_col, first_row, last_col, last_row;

    // reference model: phase 0 idle, 1 receiving, 2 flushing, 3 done
    int ph, n, k, fl;
    logic e_win, e_fd, e_err;
    int e_col, e_row;
    logic [3:0] e_brd;
    logic ex_ready, ex_shift, v_s, s_s, acc_s, got_s, prod_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0; n = 0; k = 0; fl = 0;
            e_win = 1'b0; e_col = 0; e_row = 0; e_brd = 4'b0000; e_fd = 1'b0; e_err = 1'b0;
        end
        ex_ready = (ph <= 1);
        v_s      = bus.pix_valid;
        s_s      = bus.pix_sof;
        acc_s    = v_s && ex_ready;
        ex_shift = (acc_s && (ph != 0 || s_s)) || (ph == 2);

        chk("pix_ready", int'(bus.pix_ready), int'(ex_ready));
        chk("shift_en", int'(bus.shift_en), int'(ex_shift));
        chk("win_valid", int'(bus.win_valid), int'(e_win));
        chk("out_col", int'(bus.out_col), e_col);
        chk("out_row", int'(bus.out_row), e_row);
        chk("brd_tblr", int'({bus.brd_top, bus.brd_bot, bus.brd_lft, bus.brd_rgt}), int'(e_brd));
        chk("frame_done", int'(bus.frame_done), int'(e_fd));
        chk("err_sof", int'(bus.err_sof), int'(e_err));

        if (bus.shift_en) n_shift++;
        if (bus.frame_done) n_fd++;
        if (bus.err_sof) n_err++;
        if (!bus.pix_ready) n_nrdy++;
        if (bus.win_valid) begin
            if (n_win == 0) begin
                first_win_cyc = cycle;
                first_col = int'(bus.out_col);
                first_row = int'(bus.out_row);
            end
            last_col = int'(bus.out_col);
            last_row = int'(bus.out_row);
            n_win++;
            if (test_id == 2) begin
                if (bus.out_col == 4'd0 && bus.out_row == 4'd0)
                    chk("brd_lit_0_0", int'({bus.brd_top, bus.brd_bot, bus.brd_lft, bus.brd_rgt}), 10);
                if (bus.out_col == 4'd3 && bus.out_row == 4'd1)
                    chk("brd_lit_3_1", int'({bus.brd_top, bus.brd_bot, bus.brd_lft, bus.brd_rgt}), 1);
                if (bus.out_col == 4'd1 && bus.out_row == 4'd1)
                    chk("brd_lit_1_1", int'({bus.brd_top, bus.brd_bot, bus.brd_lft, bus.brd_rgt}), 0);
            end
        end

        if (rst_n) begin
            e_win = 1'b0; e_brd = 4'b0000; e_fd = 1'b0; e_err = 1'b0;
            prod_s = 1'b0;
            got_s  = 1'b0;
            case (ph)
                0: if (acc_s) begin
                    if (s_s) begin n = 1; k = 0; ph = 1; got_s = 1'b1; end
                    else e_err = 1'b1;
                end
                1: if (acc_s) begin
                    got_s = 1'b1;
                    if (s_s) begin e_err = 1'b1; n = 1; k = 0; end
                    else n = n + 1;
                end
                2: begin prod_s = 1'b1; fl = fl - 1; if (fl == 0) ph = 3; end
                3: begin e_fd = 1'b1; ph = 0; end
                default: ph = 0;
            endcase
            if (got_s && n > LAG) prod_s = 1'b1;
            if (got_s && n == W * H) begin ph = 2; fl = LAG; end
            if (prod_s) begin
                e_win = 1'b1;
                e_col = k % W;
                e_row = k / W;
                e_brd = {e_row < HALF, e_row > H - 1 - HALF, e_col < HALF, e_col > W - 1 - HALF};
                k = k + 1;
            end
        end
    end

    task automatic clr();
        n_shift = 0; n_win = 0; n_fd = 0; n_err = 0; n_nrdy = 0;
        first_win_cyc = -1; first_col = -1; first_row = -1; last_col = -1; last_row = -1;
    endtask

    task automatic cyc_drive(input logic v, input logic s, output logic acc);
        @(posedge clk);
        #1;
        bus.pix_valid = v;
        bus.pix_sof   = s;
        acc = v & bus.pix_ready;
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random
    task automatic send_frame(input int gap_mode, input int sof_at, output int acc6_cyc);
        int p = 0;
        int guard = 0;
        int need;
        logic v;
        logic a;
        need = (sof_at > 0) ? sof_at + W * H : W * H;
        acc6_cyc = -1;
        while (p < need && guard < 400) begin
            if (gap_mode == 0) v = 1'b1;
            else if (gap_mode == 1) v = (guard % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            cyc_drive(v, (p == 0) || (sof_at > 0 && p == sof_at), a);
            if (a) begin
                if (p == 5) acc6_cyc = cycle;
                p++;
            end
            guard++;
        end
        if (p < need) chk("send_bound", p, need);
        cyc_drive(1'b0, 1'b0, a);
    endtask

    task automatic wait_done(input bit rnd);
        int g = 0;
        int start;
        logic a;
        start = n_fd;
        while (n_fd == start && g < 60) begin
            cyc_drive(rnd ? logic'($urandom_range(0, 1)) : 1'b0, 1'b0, a);
            g++;
        end
        chk("frame_done_seen", n_fd - start, 1);
    endtask

    initial begin
        int acc6;
        int sof_at;
        logic a;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        clr();

        // 1: idle after reset
        test_id = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (20) cyc_drive(1'b0, 1'b0, a);
        chk("t1_ready", int'(bus.pix_ready), 1);
        chk("t1_shift", n_shift, 0);
        chk("t1_win", n_win, 0);
        chk("t1_fd", n_fd, 0);

        // 2 and 4: back-to-back frame with border literals
        test_id = 2; clr();
        send_frame(0, 0, acc6);
        wait_done(1'b0);
        repeat (3) cyc_drive(1'b0, 1'b0, a);
        chk("t2_first_win_cyc", first_win_cyc, acc6 + 1);
        chk("t2_first_col", first_col, 0);
        chk("t2_first_row", first_row, 0);
        chk("t2_last_col", last_col, 3);
        chk("t2_last_row", last_row, 2);
        chk("t2_win", n_win, 12);
        chk("t2_shift", n_shift, 17);
        chk("t2_fd", n_fd, 1);
        chk("t2_not_ready", n_nrdy, 6);

        // 3: gaps every other cycle
        test_id = 3; clr();
        send_frame(1, 0, acc6);
        wait_done(1'b0);
        chk("t3_win", n_win, 12);
        chk("t3_shift", n_shift, 17);
        chk("t3_last_col", last_col, 3);
        chk("t3_last_row", last_row, 2);

        // 5: SOF on the 8th pixel aborts and restarts
        test_id = 5; clr();
        send_frame(0, 7, acc6);
        wait_done(1'b0);
        chk("t5_err", n_err, 1);
        chk("t5_win", n_win, 14);
        chk("t5_shift", n_shift, 24);
        chk("t5_fd", n_fd, 1);

        // 6: reset during flush
        test_id = 6; clr();
        send_frame(0, 0, acc6);
        chk("t6_in_flush", int'(bus.pix_ready), 0);
        #2; rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", int'(bus.pix_ready), 1);
        chk("t6_rst_shift", int'(bus.shift_en), 0);
        chk("t6_rst_win", int'(bus.win_valid), 0);
        chk("t6_rst_col", int'(bus.out_col), 0);
        chk("t6_rst_fd", int'(bus.frame_done), 0);
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (8) cyc_drive(1'b0, 1'b0, a);
        chk("t6_no_partial_fd", n_fd, 0);
        clr();
        send_frame(0, 0, acc6);
        wait_done(1'b0);
        chk("t6_win", n_win, 12);

        // randomized frames with gaps, stray pixels and aborts
        test_id = 7;
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) cyc_drive(1'b1, 1'b0, a);
            sof_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 0;
            send_frame(2, sof_at, acc6);
            wait_done(1'b1);
            cyc_drive(1'b0, 1'b0, a);
        end
        repeat (4) cyc_drive(1'b0, 1'b0, a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
